// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Owner states and last-served encoding live here.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    OWN_A,
    OWN_B
  } own_e;

  typedef enum logic {
    SRV_A,
    SRV_B
  } srv_e;

endpackage

// File: rtl/dmem_arb_rdpipe.sv
// Read-return pipeline: remembers which side issued a read
// and steers the syncram output to it one cycle later.
module dmem_arb_rdpipe #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_rd,
  input  logic              b_rd,
  input  logic [DATA_W-1:0] q_dmem,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata
);

  logic a_pend;
  logic b_pend;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_pend <= 1'b0;
      b_pend <= 1'b0;
    end else begin
      a_pend <= a_rd;
      b_pend <= b_rd;
    end
  end

  assign a_rvalid = a_pend;
  assign b_rvalid = b_pend;
  assign a_rdata  = a_pend ? q_dmem : '0;
  assign b_rdata  = b_pend ? q_dmem : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port dmem with
// alternating tie-break and bounded locked bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  own_e             state, state_d;
  srv_e             last_srv, srv_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             a_win, b_win;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last_srv <= SRV_B;
      cnt      <= '0;
    end else begin
      state    <= state_d;
      last_srv <= srv_d;
      cnt      <= cnt_d;
    end
  end

  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    case (state)
      IDLE: begin
        unique case (1'b1)
          a_req & ~b_req: a_win = 1'b1;
          b_req & ~a_req: b_win = 1'b1;
          a_req & b_req: begin
            a_win = (last_srv == SRV_B);
            b_win = (last_srv == SRV_A);
          end
          default: ;
        endcase
      end
      OWN_A:   a_win = a_req;
      OWN_B:   b_win = b_req;
      default: ;
    endcase
  end

  // Grants are combinational, so mask them while reset is held.
  assign a_gnt = a_win & reset;
  assign b_gnt = b_win & reset;

  always_comb begin
    state_d = state;
    srv_d   = last_srv;
    cnt_d   = cnt;
    if (a_gnt) srv_d = SRV_A;
    if (b_gnt) srv_d = SRV_B;
    case (state)
      IDLE: begin
        if (a_gnt && a_lock) begin
          cnt_d = ONE;
          if (MAXC != ONE) state_d = OWN_A;
        end else if (b_gnt && b_lock) begin
          cnt_d = ONE;
          if (MAXC != ONE) state_d = OWN_B;
        end
      end
      OWN_A: begin
        if (a_gnt) cnt_d = cnt + ONE;
        if (!a_req || !a_lock) state_d = IDLE;
        else if (cnt_d == MAXC) state_d = IDLE;
      end
      OWN_B: begin
        if (b_gnt) cnt_d = cnt + ONE;
        if (!b_req || !b_lock) state_d = IDLE;
        else if (cnt_d == MAXC) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    address_dmem = '0;
    data         = '0;
    wren         = 1'b0;
    if (a_gnt) begin
      address_dmem = a_addr;
      data         = a_wdata;
      wren         = a_we;
    end else if (b_gnt) begin
      address_dmem = b_addr;
      data         = b_wdata;
      wren         = b_we;
    end
  end

  dmem_arb_rdpipe #(
    .DATA_W(DATA_W)
  ) u_rdpipe (
    .clock   (clock),
    .reset   (reset),
    .a_rd    (a_gnt & ~a_we),
    .b_rd    (b_gnt & ~b_we),
    .q_dmem  (q_dmem),
    .a_rvalid(a_rvalid),
    .a_rdata (a_rdata),
    .b_rvalid(b_rvalid),
    .b_rdata (b_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected
// grants and read returns, a negedge monitor pops and compares.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 0, a_we = 0, a_lock = 0;
  logic        b_req = 0, b_we = 0, b_lock = 0;
  logic [11:0] a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, wren;
  logic [31:0] a_rdata, b_rdata, data, q_dmem;
  logic [11:0] address_dmem;

  logic [31:0] mem [0:4095];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          who;
    logic        wren;
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
  } gexp_t;

  typedef struct {
    int          who;
    logic [31:0] data;
    int          cyc;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t g;
  rexp_t r;
  int    mwho;

  dmem_arbiter dut (
    .clock       (clk),
    .reset       (rst_n),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_lock      (a_lock),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_lock      (b_lock),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .a_gnt       (a_gnt),
    .b_gnt       (b_gnt),
    .a_rvalid    (a_rvalid),
    .b_rvalid    (b_rvalid),
    .a_rdata     (a_rdata),
    .b_rdata     (b_rdata),
    .address_dmem(address_dmem),
    .data        (data),
    .wren        (wren),
    .q_dmem      (q_dmem)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // syncram model: registered address, one-cycle read latency
  always @(posedge clk) begin
    if (wren) mem[address_dmem] <= data;
    q_dmem <= mem[address_dmem];
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      vectors++;
      if (a_gnt || b_gnt || a_rvalid || b_rvalid || wren ||
          a_rdata != 0 || b_rdata != 0 ||
          address_dmem != 0 || data != 0) begin
        miscompares++;
        $display("FAIL reset_zero cyc=%0d gnt=%b%b rv=%b%b we=%b",
                 cyc, a_gnt, b_gnt, a_rvalid, b_rvalid, wren);
      end
    end else begin
      if (a_gnt || b_gnt) begin
        vectors++;
        mwho = (a_gnt && b_gnt) ? 3 : (a_gnt ? 1 : 2);
        if (gq.size() == 0) begin
          miscompares++;
          $display("FAIL grant_unexpected cyc=%0d who=%0d", cyc, mwho);
        end else begin
          g = gq.pop_front();
          if (mwho != g.who || cyc != g.cyc || wren != g.wren ||
              address_dmem != g.addr || data != g.data) begin
            miscompares++;
            $display("FAIL grant got who=%0d cyc=%0d we=%b a=%h d=%h req who=%0d cyc=%0d we=%b a=%h d=%h",
                     mwho, cyc, wren, address_dmem, data,
                     g.who, g.cyc, g.wren, g.addr, g.data);
          end
        end
      end else begin
        vectors++;
        if (wren || address_dmem != 0 || data != 0) begin
          miscompares++;
          $display("FAIL idle_bus cyc=%0d we=%b a=%h d=%h required zero",
                   cyc, wren, address_dmem, data);
        end
      end
      if (a_rvalid || b_rvalid) begin
        vectors++;
        mwho = (a_rvalid && b_rvalid) ? 3 : (a_rvalid ? 1 : 2);
        if (rq.size() == 0) begin
          miscompares++;
          $display("FAIL rvalid_unexpected cyc=%0d who=%0d", cyc, mwho);
        end else begin
          r = rq.pop_front();
          if (mwho != r.who || cyc != r.cyc ||
              (a_rvalid ? a_rdata : b_rdata) != r.data) begin
            miscompares++;
            $display("FAIL rdata got who=%0d cyc=%0d d=%h req who=%0d cyc=%0d d=%h",
                     mwho, cyc, a_rvalid ? a_rdata : b_rdata,
                     r.who, r.cyc, r.data);
          end
        end
      end else if (a_rdata != 0 || b_rdata != 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rdata_idle cyc=%0d a=%h b=%h required 0",
                 cyc, a_rdata, b_rdata);
      end
    end
  end

  task automatic set_a(input logic rq_, input logic we_,
                       input logic lk_, input logic [11:0] ad_,
                       input logic [31:0] wd_);
    a_req = rq_; a_we = we_; a_lock = lk_;
    a_addr = ad_; a_wdata = wd_;
  endtask

  task automatic set_b(input logic rq_, input logic we_,
                       input logic lk_, input logic [11:0] ad_,
                       input logic [31:0] wd_);
    b_req = rq_; b_we = we_; b_lock = lk_;
    b_addr = ad_; b_wdata = wd_;
  endtask

  // who: 0 none, 1 A, 2 B; rd: expect read data next cycle
  task automatic step(input int who, input logic rd,
                      input logic [31:0] rdat);
    if (who == 1) gq.push_back('{1, a_we, a_addr, a_wdata, cyc});
    if (who == 2) gq.push_back('{2, b_we, b_addr, b_wdata, cyc});
    if (rd) rq.push_back('{who, rdat, cyc + 1});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_a(0, 0, 0, 12'h0, 32'h0);
    set_b(0, 0, 0, 12'h0, 32'h0);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // reset with requests active: everything must stay 0
    set_a(1, 0, 1, 12'h055, 32'h1);
    set_b(1, 1, 1, 12'h066, 32'h2);
    @(posedge clk); #1;
    step(0, 0, 0);
    step(0, 0, 0);
    idle(0);
    rst_n = 1'b1;

    // single A write then read-back
    set_a(1, 1, 0, 12'h010, 32'hDEADBEEF);
    step(1, 0, 0);
    idle(1);
    set_a(1, 0, 0, 12'h010, 32'h0);
    step(1, 1, 32'hDEADBEEF);
    idle(2);

    // tie alternation from reset: A, B, A, B
    rst_n = 1'b0;
    step(0, 0, 0);
    rst_n = 1'b1;
    set_a(1, 1, 0, 12'h020, 32'h0000_00A1);
    set_b(1, 1, 0, 12'h021, 32'h0000_00B1);
    step(1, 0, 0);
    step(2, 0, 0);
    step(1, 0, 0);
    step(2, 0, 0);
    idle(1);

    // make A last served so B wins the locked tie
    set_a(1, 1, 0, 12'h030, 32'h0000_0030);
    step(1, 0, 0);
    idle(1);
    set_a(1, 1, 0, 12'h031, 32'h0000_0031);
    set_b(1, 1, 1, 12'h040, 32'h0000_0040);
    for (int i = 0; i < 8; i++) step(2, 0, 0);
    step(1, 0, 0);
    idle(1);

    // B locked, lock dropped on third grant
    set_a(1, 1, 0, 12'h050, 32'h0000_0050);
    step(1, 0, 0);
    set_b(1, 1, 1, 12'h060, 32'h0000_0060);
    step(2, 0, 0);
    step(2, 0, 0);
    b_lock = 1'b0;
    step(2, 0, 0);
    step(1, 0, 0);
    idle(1);

    // back-to-back reads return in address order
    set_a(1, 1, 0, 12'h001, 32'h1111_1111);
    step(1, 0, 0);
    set_a(1, 1, 0, 12'h002, 32'h2222_2222);
    step(1, 0, 0);
    set_a(1, 1, 0, 12'h003, 32'h3333_3333);
    step(1, 0, 0);
    set_a(1, 0, 0, 12'h001, 32'h0);
    step(1, 1, 32'h1111_1111);
    a_addr = 12'h002;
    step(1, 1, 32'h2222_2222);
    a_addr = 12'h003;
    step(1, 1, 32'h3333_3333);
    idle(2);

    // read grant, then reset: the pending read is dropped
    set_a(1, 0, 0, 12'h001, 32'h0);
    step(1, 0, 0);
    rst_n = 1'b0;
    set_a(1, 1, 0, 12'h070, 32'h0000_0070);
    set_b(1, 1, 0, 12'h071, 32'h0000_0071);
    step(0, 0, 0);
    step(0, 0, 0);
    rst_n = 1'b1;
    step(1, 0, 0);
    idle(2);

    vectors++;
    if (gq.size() != 0 || rq.size() != 0) begin
      miscompares++;
      $display("FAIL leftover grants=%0d reads=%0d required 0",
               gq.size(), rq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
